// File: rtl/gesture_pkg.sv
// rtl/gesture_pkg.sv - shared state encoding and frame geometry defaults for the gesture frame sequencer
package gesture_pkg;

  localparam int IMG_W_DEF = 160;
  localparam int IMG_H_DEF = 120;
  localparam int SIGN_W    = 5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    BG_SCAN   = 3'd2,
    SIGN_SCAN = 3'd3,
    FLUSH     = 3'd4,
    PALM      = 3'd5,
    FINGER    = 3'd6,
    SIGN      = 3'd7
  } gfs_state_e;

  function automatic logic is_stage(input gfs_state_e s);
    return (s == PALM) || (s == FINGER) || (s == SIGN);
  endfunction

endpackage

// File: rtl/gfs_raster_counter.sv
// rtl/gfs_raster_counter.sv - row/col raster counter with clear, line wrap and last-pixel flag
module gfs_raster_counter #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int COL_W = 8,
  parameter int ROW_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last_pix
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             col_end;
  logic             row_end;

  assign col_end  = (col_q == COL_W'(IMG_W - 1));
  assign row_end  = (row_q == ROW_W'(IMG_H - 1));
  assign last_pix = inc && col_end && row_end;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (inc) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row = row_q;
  assign col = col_q;

endmodule

// File: rtl/gesture_frame_sequencer.sv
// rtl/gesture_frame_sequencer.sv - frame-level sequencer for the sign-to-text pipeline
// Optional stage watchdog enabled by defining GFS_TIMEOUT_EN.
module gesture_frame_sequencer
  import gesture_pkg::*;
#(
  parameter int IMG_W     = IMG_W_DEF,
  parameter int IMG_H     = IMG_H_DEF,
  parameter int COL_W     = 8,
  parameter int ROW_W     = 7,
  parameter int FLUSH_CYC = 4,
  parameter int TMO_CYC   = 4095
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sof,
  input  logic                   pix_valid,
  input  logic                   capture_bg,
  input  logic                   train_sw,
  input  logic [7:0]             palm_height,
  input  logic                   palm_done,
  input  logic                   finger_done,
  input  logic                   sign_done,
  input  logic [SIGN_W-1:0]      sign_code,
  output logic [ROW_W-1:0]       row,
  output logic [COL_W-1:0]       col,
  output logic                   bg_we,
  output logic                   bg_re,
  output logic [ROW_W+COL_W-1:0] bg_addr,
  output logic                   palm_start,
  output logic                   finger_start,
  output logic                   sign_start,
  output logic [7:0]             palm_height_test,
  output logic [SIGN_W-1:0]      sign_value,
  output logic                   sign_valid,
  output logic                   bg_ready,
  output logic                   busy,
  output logic                   err
);

  localparam int FL_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  gfs_state_e        state_q, state_d;
  logic              pend_q, pend_d;
  logic [FL_W-1:0]   flush_q, flush_d;
  logic              palm_start_q, palm_start_d;
  logic              finger_start_q, finger_start_d;
  logic              sign_start_q, sign_start_d;
  logic [7:0]        ph_q, ph_d;
  logic [SIGN_W-1:0] sv_q, sv_d;
  logic              svalid_q, svalid_d;
  logic              bg_ready_q, bg_ready_d;
  logic              err_q, err_d;
  logic              cnt_clr, cnt_inc, last_pix;
  logic              scanning;

  gfs_raster_counter #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .COL_W(COL_W),
    .ROW_W(ROW_W)
  ) u_raster (
    .clk     (clk),
    .rst_n   (rst),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .row     (row),
    .col     (col),
    .last_pix(last_pix)
  );

  assign scanning = (state_q == BG_SCAN) || (state_q == SIGN_SCAN);

`ifdef GFS_TIMEOUT_EN
  logic [11:0] wdog_q, wdog_d;
  logic        wdog_hit;
  assign wdog_hit = is_stage(state_q) && (wdog_q == 12'(TMO_CYC - 1));
`endif

  always_comb begin
    state_d        = state_q;
    pend_d         = pend_q | capture_bg;
    flush_d        = '0;
    palm_start_d   = 1'b0;
    finger_start_d = 1'b0;
    sign_start_d   = 1'b0;
    ph_d           = ph_q;
    sv_d           = sv_q;
    svalid_d       = 1'b0;
    bg_ready_d     = bg_ready_q;
    err_d          = err_q;
    cnt_clr        = 1'b0;
    cnt_inc        = scanning && pix_valid && !sof;

    case (state_q)
      IDLE: begin
        if (pend_q || bg_ready_q) state_d = ARMED;
      end
      ARMED: begin
        if (sof) begin
          cnt_clr = 1'b1;
          if (pend_q) begin
            state_d = BG_SCAN;
            pend_d  = capture_bg;
          end else begin
            state_d = SIGN_SCAN;
          end
        end
      end
      BG_SCAN, SIGN_SCAN: begin
        // A mid-frame sof restarts the same scan from pixel 0.
        if (sof) begin
          cnt_clr = 1'b1;
        end else if (last_pix) begin
          if (state_q == BG_SCAN) begin
            state_d    = IDLE;
            bg_ready_d = 1'b1;
          end else begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        flush_d = flush_q + 1'b1;
        if (flush_q == FL_W'(FLUSH_CYC - 1)) begin
          flush_d      = '0;
          state_d      = PALM;
          palm_start_d = 1'b1;
        end
      end
      PALM: begin
        if (palm_done) begin
          if (train_sw) ph_d = palm_height;
          state_d        = FINGER;
          finger_start_d = 1'b1;
        end
      end
      FINGER: begin
        if (finger_done) begin
          state_d      = SIGN;
          sign_start_d = 1'b1;
        end
      end
      SIGN: begin
        if (sign_done) begin
          sv_d     = sign_code;
          svalid_d = 1'b1;
          state_d  = ARMED;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef GFS_TIMEOUT_EN
    if (wdog_hit && (state_d == state_q)) begin
      state_d = ARMED;
      err_d   = 1'b1;
    end
    wdog_d = (is_stage(state_q) && (state_d == state_q)) ? wdog_q + 1'b1 : 12'd0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      pend_q         <= 1'b0;
      flush_q        <= '0;
      palm_start_q   <= 1'b0;
      finger_start_q <= 1'b0;
      sign_start_q   <= 1'b0;
      ph_q           <= 8'd0;
      sv_q           <= '0;
      svalid_q       <= 1'b0;
      bg_ready_q     <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_q         <= pend_d;
      flush_q        <= flush_d;
      palm_start_q   <= palm_start_d;
      finger_start_q <= finger_start_d;
      sign_start_q   <= sign_start_d;
      ph_q           <= ph_d;
      sv_q           <= sv_d;
      svalid_q       <= svalid_d;
      bg_ready_q     <= bg_ready_d;
      err_q          <= err_d;
    end
  end

`ifdef GFS_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wdog_q <= 12'd0;
    else      wdog_q <= wdog_d;
  end
`endif

  assign bg_we            = (state_q == BG_SCAN) && pix_valid;
  assign bg_re            = (state_q == SIGN_SCAN) && pix_valid;
  assign bg_addr          = {row, col};
  assign palm_start       = palm_start_q;
  assign finger_start     = finger_start_q;
  assign sign_start       = sign_start_q;
  assign palm_height_test = ph_q;
  assign sign_value       = sv_q;
  assign sign_valid       = svalid_q;
  assign bg_ready         = bg_ready_q;
  assign busy             = (state_q != IDLE);
  assign err              = err_q;

endmodule

// File: tb/tb_gesture_frame_sequencer.sv
// tb/tb_gesture_frame_sequencer.sv - directed self-checking bench for gesture_frame_sequencer
module tb_gesture_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst, sof, pix_valid, capture_bg, train_sw;
  logic [7:0]  palm_height;
  logic        palm_done, finger_done, sign_done;
  logic [4:0]  sign_code;
  logic [6:0]  row;
  logic [7:0]  col;
  logic        bg_we, bg_re;
  logic [14:0] bg_addr;
  logic        palm_start, finger_start, sign_start;
  logic [7:0]  palm_height_test;
  logic [4:0]  sign_value;
  logic        sign_valid, bg_ready, busy, err;

  int n_cmp = 0;
  int n_err = 0;
  int ps_cnt = 0, fs_cnt = 0, ss_cnt = 0, sv_cnt = 0;
  int cnt, lat;
  logic [14:0] last_addr;

  gesture_frame_sequencer dut (
    .clk(clk), .rst(rst), .sof(sof), .pix_valid(pix_valid), .capture_bg(capture_bg),
    .train_sw(train_sw), .palm_height(palm_height), .palm_done(palm_done),
    .finger_done(finger_done), .sign_done(sign_done), .sign_code(sign_code),
    .row(row), .col(col), .bg_we(bg_we), .bg_re(bg_re), .bg_addr(bg_addr),
    .palm_start(palm_start), .finger_start(finger_start), .sign_start(sign_start),
    .palm_height_test(palm_height_test), .sign_value(sign_value), .sign_valid(sign_valid),
    .bg_ready(bg_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (palm_start)   ps_cnt++;
    if (finger_start) fs_cnt++;
    if (sign_start)   ss_cnt++;
    if (sign_valid)   sv_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_pixels(input int n, output int we_cnt, output logic [14:0] addr);
    we_cnt = 0;
    addr   = '0;
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      @(negedge clk);
      if (bg_we || bg_re) we_cnt++;
      addr = bg_addr;
      tick();
    end
    pix_valid = 1'b0;
  endtask

  task automatic measure_palm_latency(output int l);
    l = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (palm_start) begin
        l = k;
        break;
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0; sof = 0; pix_valid = 0; capture_bg = 0; train_sw = 0;
    palm_height = 8'd0; palm_done = 0; finger_done = 0; sign_done = 0; sign_code = 5'd0;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_addr", bg_addr, 0);
    check("rst_bg_ready", bg_ready, 0);
    check("rst_err", err, 0);
    rst = 1'b1;
    tick();
    check("idle_stays", busy, 0);

    // background capture frame
    capture_bg = 1'b1; tick(); capture_bg = 1'b0;
    tick();
    check("armed_busy", busy, 1);
    sof = 1'b1; tick(); sof = 1'b0;
    run_pixels(19200, cnt, last_addr);
    check("bg_we_count", cnt, 19200);
    check("bg_last_addr", last_addr, {7'd119, 8'd159});
    check("bg_ready_set", bg_ready, 1);
    tick(); tick();
    check("bg_no_palm_start", ps_cnt, 0);
    check("rearmed", busy, 1);

    // stray done pulse while ARMED must be ignored
    sign_code = 5'd3; sign_done = 1'b1; tick(); sign_done = 1'b0;
    @(negedge clk);
    check("stray_sign_valid", sign_valid, 0);
    check("stray_sign_value", sign_value, 0);
    tick();

    // sign frame with training
    sof = 1'b1; tick(); sof = 1'b0;
    run_pixels(19200, cnt, last_addr);
    check("bg_re_count", cnt, 19200);
    measure_palm_latency(lat);
    check("palm_latency", lat, 5);
    train_sw = 1'b1; palm_height = 8'd72; palm_done = 1'b1;
    tick(); palm_done = 1'b0;
    @(negedge clk);
    check("palm_start_width", palm_start, 0);
    check("finger_start", finger_start, 1);
    check("ph_trained", palm_height_test, 72);
    finger_done = 1'b1; tick(); finger_done = 1'b0;
    @(negedge clk);
    check("finger_start_width", finger_start, 0);
    check("sign_start", sign_start, 1);
    sign_code = 5'd9; sign_done = 1'b1; tick(); sign_done = 1'b0;
    @(negedge clk);
    check("sign_start_width", sign_start, 0);
    check("sign_valid", sign_valid, 1);
    check("sign_value", sign_value, 9);
    tick();
    @(negedge clk);
    check("sign_valid_width", sign_valid, 0);
    check("start_counts", {ps_cnt[7:0], fs_cnt[7:0], ss_cnt[7:0], sv_cnt[7:0]}, 32'h01010101);

    // aborted sign scan, then full frame with sof ignored in PALM
    tick();
    train_sw = 1'b0; palm_height = 8'd50;
    sof = 1'b1; tick(); sof = 1'b0;
    run_pixels(40 * 160 + 5, cnt, last_addr);
    @(negedge clk);
    check("mid_row", row, 40);
    check("mid_col", col, 5);
    tick();
    sof = 1'b1; tick(); sof = 1'b0;
    @(negedge clk);
    check("abort_addr", bg_addr, 0);
    check("abort_busy", busy, 1);
    tick();
    run_pixels(19200, cnt, last_addr);
    check("abort_no_flush", ps_cnt, 1);
    measure_palm_latency(lat);
    check("palm_latency2", lat, 5);
    tick();
    sof = 1'b1; tick(); sof = 1'b0;
    pix_valid = 1'b1;
    @(negedge clk);
    check("palm_sof_ignored", bg_re, 0);
    pix_valid = 1'b0;
    palm_done = 1'b1; tick(); palm_done = 1'b0;
    @(negedge clk);
    check("finger_start2", finger_start, 1);
    check("ph_held", palm_height_test, 72);

`ifdef GFS_TIMEOUT_EN
    cnt = 0;
    while (!err && cnt < 5000) begin
      tick();
      cnt++;
    end
    check("tmo_cycles", cnt, 4095);
    check("tmo_err", err, 1);
    check("tmo_armed", busy, 1);
    check("tmo_no_valid", sv_cnt, 1);
    check("tmo_sign_value", sign_value, 9);
    tick();
    check("tmo_no_sign_start", ss_cnt, 1);
`else
    for (int i = 0; i < 100; i++) tick();
    check("no_tmo_err", err, 0);
    check("finger_waits", ss_cnt, 1);
    finger_done = 1'b1; tick(); finger_done = 1'b0;
    sign_code = 5'd21; sign_done = 1'b1; tick(); sign_done = 1'b0;
    @(negedge clk);
    check("sign_value2", sign_value, 21);
    check("sign_valid2", sv_cnt, 1);
    tick();
`endif

    // asynchronous reset in the middle of a sign scan
    sof = 1'b1; tick(); sof = 1'b0;
    run_pixels(300, cnt, last_addr);
    pix_valid = 1'b1;
    rst = 1'b0;
    tick(); tick(); tick();
    check("mrst_busy", busy, 0);
    check("mrst_addr", bg_addr, 0);
    check("mrst_bg_re", bg_re, 0);
    check("mrst_bg_ready", bg_ready, 0);
    check("mrst_ph", palm_height_test, 0);
    check("mrst_sign_value", sign_value, 0);
    check("mrst_strobes", {palm_start, finger_start, sign_start, sign_valid, err}, 0);
    pix_valid = 1'b0;
    rst = 1'b1;
    tick(); tick();
    check("mrst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gesture_frame_sequencer.md
Name: gesture_frame_sequencer

Overview:
- Frame-level controller for the sign-to-text pipeline (colour convert -> background difference -> palm -> finger -> sign).
- Generates pixel raster counters and background-buffer write/read control.
- Sequences the palm, finger and sign stages with start/done handshakes.
- Captures the palm-height training value and presents the final sign with a valid pulse.

Parameters:
- IMG_W, 160, pixels per line
- IMG_H, 120, lines per frame
- COL_W, 8, column counter width (>= clog2(IMG_W))
- ROW_W, 7, row counter width (>= clog2(IMG_H))
- FLUSH_CYC, 4, cycles after last pixel before palm start (datapath pipeline depth)
- TMO_CYC, 4095, stage watchdog limit (used only with GFS_TIMEOUT_EN)

Ports:
- clk, input, 1, system clock
- rst, input, 1, asynchronous active-low reset
- sof, input, 1, camera start-of-frame pulse
- pix_valid, input, 1, pixel strobe on RGB inputs
- capture_bg, input, 1, request: next frame is background
- train_sw, input, 1, training mode switch
- palm_height, input, 8, palm height from palm stage
- palm_done, input, 1, palm stage finished (pulse)
- finger_done, input, 1, finger stage finished (pulse)
- sign_done, input, 1, sign stage finished (pulse)
- sign_code, input, 5, sign identifier from sign stage
- row, output, ROW_W, current pixel row
- col, output, COL_W, current pixel column
- bg_we, output, 1, background buffer write enable
- bg_re, output, 1, background buffer read enable (sign frames)
- bg_addr, output, ROW_W+COL_W, {row,col}
- palm_start, output, 1, one-cycle start to palm stage
- finger_start, output, 1, one-cycle start to finger stage
- sign_start, output, 1, one-cycle start to sign stage
- palm_height_test, output, 8, trained palm height
- sign_value, output, 5, last recognised sign
- sign_valid, output, 1, one-cycle pulse when sign_value updates
- bg_ready, output, 1, background captured at least once
- busy, output, 1, not IDLE
- err, output, 1, sticky stage timeout (0 without macro)

Behaviour:
- Reset (rst=0, async): state IDLE; row, col, bg_addr = 0; all strobes 0; palm_height_test = 8'd0; sign_value = 0; bg_ready = 0; err = 0; pending-capture flag cleared.
- capture_bg sets a pending flag in any state; the flag is cleared on entry to BG_SCAN.
- IDLE -> ARMED when pending flag set or bg_ready = 1.
- ARMED:
  - On sof: -> BG_SCAN if pending flag set, else -> SIGN_SCAN.
  - row/col are cleared on sof.
- BG_SCAN / SIGN_SCAN:
  - Each pix_valid: col++; at col = IMG_W-1, col wraps to 0 and row++.
  - bg_we = pix_valid in BG_SCAN; bg_re = pix_valid in SIGN_SCAN; both combinational from state and pix_valid, with bg_addr = {row,col} of the same cycle.
  - Last pixel (row = IMG_H-1, col = IMG_W-1, pix_valid): BG_SCAN -> IDLE and sets bg_ready; SIGN_SCAN -> FLUSH.
  - sof mid-scan: abort, counters cleared, restart the same scan type on that sof; no stage starts.
- FLUSH: count FLUSH_CYC cycles, then -> PALM with palm_start = 1 for the first PALM cycle.
- PALM:
  - Wait palm_done. If train_sw = 1, latch palm_height into palm_height_test on palm_done.
  - palm_done -> FINGER with finger_start pulse.
- FINGER: finger_done -> SIGN with sign_start pulse.
- SIGN:
  - sign_done -> latch sign_code into sign_value; sign_valid = 1 next cycle.
  - Then -> ARMED.
  - In training mode, sign_value is still updated.
- Stage handling:
  - Done pulses arriving in other states are ignored.
  - Start pulses are registered and exactly one cycle wide.
- Latency:
  - Last pixel -> palm_start = FLUSH_CYC+1 cycles.
  - sign_done -> sign_valid = 1 cycle.
- sof during FLUSH/PALM/FINGER/SIGN is ignored (frame dropped). A frame is processed only after returning to ARMED.
- busy = (state != IDLE).

Optional Feature:
- GFS_TIMEOUT_EN defined:
  - A 12-bit watchdog counts in PALM/FINGER/SIGN and clears on state change.
  - On reaching TMO_CYC: set sticky err, return to ARMED, sign_value unchanged, no sign_valid.
  - err clears only on reset.
- Undefined: no counter; err tied 0; stages wait indefinitely.

Decomposition:
- Shared package gesture_pkg:
  - state encoding localparams: IDLE=0, ARMED=1, BG_SCAN=2, SIGN_SCAN=3, FLUSH=4, PALM=5, FINGER=6, SIGN=7
  - IMG_W/IMG_H defaults
  - sign code width 5
- One natural sub-module: gfs_raster_counter (row/col counter with clear, wrap and last-pixel flag).

Test Plan:
- Reset mid-SIGN_SCAN (rst low 3 cycles) -> all outputs at reset values; state IDLE; bg_ready = 0.
- capture_bg, sof, 160x120 pixel_valid -> 19200 bg_we pulses; last bg_addr = {7'd119,8'd159}; bg_ready = 1; no palm_start.
- Sign frame then palm_done/finger_done/sign_done with sign_code = 5'd9 -> palm_start exactly 5 cycles after last pixel; single-cycle starts in order; sign_value = 9; one sign_valid.
- train_sw = 1, palm_height = 8'd72 at palm_done -> palm_height_test = 72; with train_sw = 0 and palm_height = 50 -> value stays 72.
- sof at row 40 of a sign scan -> counters restart at 0; no FLUSH entry from the aborted frame; sof during PALM is ignored.
- GFS_TIMEOUT_EN defined, no finger_done -> err = 1 after 4095 FINGER cycles; state ARMED; no sign_valid.
